// File: rtl/pll_lock_ctrl.sv
// PLL reset/lock sequencer: holds the PLL in reset, qualifies a synchronized lock, then releases SYS_RESET.
// Define PLL_LOCK_BYPASS_FALLBACK_EN to fall back to the reference clock (PLL bypassed) in FAULT.
module pll_lock_ctrl #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 4096,
  parameter int unsigned STABLE_CYCLES = 256,
  parameter int unsigned MAX_RETRIES   = 3
) (
  input  logic       REFERENCECLK,
  input  logic       RESET,
  input  logic       RESTART,
  input  logic       PLL_LOCK,
  output logic       PLL_RESETB,
  output logic       PLL_BYPASS,
  output logic       SYS_RESET,
  output logic       LOCK_LOST,
  output logic [2:0] STATE,
  output logic [2:0] RETRY_CNT
);

  localparam int unsigned MAX_AB  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned MAX_CYC = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
  localparam int unsigned CW      = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;

  localparam logic [CW-1:0] HOLD_LAST   = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] WAIT_LAST   = CW'(LOCK_TIMEOUT - 1);
  // The WAIT_LOCK cycle that first sees lock_s high is the first of the qualifying run.
  localparam logic [CW-1:0] STABLE_LAST = CW'((STABLE_CYCLES > 1) ? STABLE_CYCLES - 2 : 0);
  localparam logic [2:0]    RETRY_LIMIT = 3'(MAX_RETRIES);

  typedef enum logic [2:0] {
    HOLD      = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    retry, retry_nxt;
  logic          sync1, lock_s;
  logic          resetb_nxt, bypass_nxt, sysrst_nxt, lost_nxt;

  always_ff @(posedge REFERENCECLK) begin
    if (RESET) begin
      sync1  <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      sync1  <= PLL_LOCK;
      lock_s <= sync1;
    end
  end

  always_ff @(posedge REFERENCECLK) begin
    if (RESET) begin
      state <= HOLD;
      cnt   <= '0;
      retry <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      retry <= retry_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    retry_nxt = retry;
    lost_nxt  = 1'b0;
    if (RESTART) begin
      state_nxt = HOLD;
      retry_nxt = '0;
    end else begin
      case (state)
        HOLD:      if (cnt == HOLD_LAST) state_nxt = WAIT_LOCK;
        WAIT_LOCK: begin
          if (lock_s) begin
            state_nxt = STABLE;
          end else if (cnt == WAIT_LAST) begin
            retry_nxt = retry + 3'd1;
            state_nxt = (retry_nxt == RETRY_LIMIT) ? FAULT : HOLD;
          end
        end
        STABLE: begin
          if (!lock_s) begin
            state_nxt = WAIT_LOCK;
          end else if (cnt == STABLE_LAST) begin
            state_nxt = RUN;
            retry_nxt = '0;
          end
        end
        RUN: begin
          retry_nxt = '0;
          if (!lock_s) begin
            state_nxt = HOLD;
            lost_nxt  = 1'b1;
          end
        end
        FAULT:   state_nxt = FAULT;
        default: state_nxt = HOLD;
      endcase
    end
    // Shared dwell counter: cleared on any state entry, saturates instead of wrapping.
    if (RESTART || (state_nxt != state)) begin
      cnt_nxt = '0;
    end else if (cnt != '1) begin
      cnt_nxt = cnt + 1'b1;
    end else begin
      cnt_nxt = cnt;
    end
  end

  always_comb begin
    resetb_nxt = 1'b1;
    bypass_nxt = 1'b0;
    sysrst_nxt = 1'b1;
    case (state_nxt)
      HOLD: resetb_nxt = 1'b0;
      RUN:  sysrst_nxt = 1'b0;
      FAULT: begin
`ifdef PLL_LOCK_BYPASS_FALLBACK_EN
        bypass_nxt = 1'b1;
        sysrst_nxt = 1'b0;
`else
        resetb_nxt = 1'b0;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge REFERENCECLK) begin
    if (RESET) begin
      PLL_RESETB <= 1'b0;
      PLL_BYPASS <= 1'b0;
      SYS_RESET  <= 1'b1;
      LOCK_LOST  <= 1'b0;
    end else begin
      PLL_RESETB <= resetb_nxt;
      PLL_BYPASS <= bypass_nxt;
      SYS_RESET  <= sysrst_nxt;
      LOCK_LOST  <= lost_nxt;
    end
  end

  assign STATE     = state;
  assign RETRY_CNT = retry;

endmodule

// File: doc/pll_lock_ctrl.md
PLL_LOCK_CTRL -- requirements
Module: pll_lock_ctrl

Interface
REQ-001 Parameter RST_CYCLES, default 16: cycles PLL_RESETB is held low on each attempt; minimum 2.
REQ-002 Parameter LOCK_TIMEOUT, default 4096: cycles allowed in WAIT_LOCK per attempt before that attempt fails.
REQ-003 Parameter STABLE_CYCLES, default 256: consecutive synchronized-lock-high cycles required before SYS_RESET release.
REQ-004 Parameter MAX_RETRIES, default 3, range 1..7: failed attempts allowed before FAULT.
REQ-005 REFERENCECLK  in  1  sole clock; all logic on its rising edge.
REQ-006 RESET  in  1  synchronous, active-high reset.
REQ-007 RESTART  in  1  restart request, sampled each cycle; forces a full re-sequence.
REQ-008 PLL_LOCK  in  1  PLL LOCK output; asynchronous to REFERENCECLK.
REQ-009 PLL_RESETB  out  1  drives PLL RESETB; active low.
REQ-010 PLL_BYPASS  out  1  drives PLL BYPASS.
REQ-011 SYS_RESET  out  1  active-high reset for the PLL-clocked logic.
REQ-012 LOCK_LOST  out  1  one-cycle pulse when lock drops in RUN.
REQ-013 STATE  out  3  current state: HOLD=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAULT=4.
REQ-014 RETRY_CNT  out  3  failed attempts in the current sequence.

Function
REQ-015 PLL_LOCK SHALL pass through a 2-flop synchronizer (lock_s) before use; no other path from PLL_LOCK is permitted.
REQ-016 All outputs SHALL be registered; the outputs for state S appear in the cycle STATE first reads S.
REQ-017 HOLD: PLL_RESETB=0, SYS_RESET=1, PLL_BYPASS=0; after exactly RST_CYCLES cycles in HOLD, go to WAIT_LOCK.
REQ-018 WAIT_LOCK: PLL_RESETB=1, SYS_RESET=1; if lock_s=1, go to STABLE; otherwise, on the LOCK_TIMEOUT-th cycle, increment RETRY_CNT.
REQ-019 On that timeout, the next state SHALL be FAULT if the incremented RETRY_CNT equals MAX_RETRIES, else HOLD.
REQ-020 STABLE: SYS_RESET=1; on lock_s=0, go to WAIT_LOCK with the timeout counter cleared; after STABLE_CYCLES consecutive lock_s=1 cycles, go to RUN.
REQ-021 RUN: SYS_RESET=0, RETRY_CNT cleared to 0.
REQ-022 In RUN, lock_s=0 SHALL raise LOCK_LOST for exactly one cycle, assert SYS_RESET in that same cycle, and go to HOLD.
REQ-023 RESTART=1 in any state SHALL go to HOLD with RETRY_CNT=0 and all counters cleared.
REQ-024 RESTART SHALL take priority over simultaneous lock, timeout and stability events.
REQ-025 A single shared counter SHALL be cleared on every state entry; its width SHALL be sized to the largest of the three cycle parameters; it SHALL never wrap.
REQ-026 FAULT SHALL be left only via RESTART or RESET.

Reset
REQ-027 RESET=1 SHALL set: STATE=HOLD, counters=0, RETRY_CNT=0, synchronizer=0, PLL_RESETB=0, PLL_BYPASS=0, SYS_RESET=1, LOCK_LOST=0.
REQ-028 RESET SHALL take priority over RESTART.
REQ-029 RESET asserted mid-sequence SHALL abort the sequence with no residual state.
REQ-030 HOLD timing SHALL restart from the first cycle after RESET deasserts.

Configuration
REQ-031 Macro PLL_LOCK_BYPASS_FALLBACK_EN defined: in FAULT, PLL_BYPASS=1, PLL_RESETB=1, SYS_RESET=0; the system runs on the reference clock.
REQ-032 Macro PLL_LOCK_BYPASS_FALLBACK_EN undefined: in FAULT, PLL_BYPASS=0 (tied 0 in all states), PLL_RESETB=0, SYS_RESET=1.

Verification
Bench parameters for all scenarios: RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, MAX_RETRIES=2.
REQ-033 Nominal: release RESET, raise PLL_LOCK 5 cycles after PLL_RESETB rises -> PLL_RESETB low exactly 4 cycles; SYS_RESET falls 2+8=10 cycles after PLL_LOCK rises; STATE=3.
REQ-034 Glitch in STABLE: after 5 cycles in STABLE, drop PLL_LOCK for 1 cycle -> STATE returns to 1, no SYS_RESET release; RUN reached 8 lock_s cycles after lock restores.
REQ-035 Timeout/fault: PLL_LOCK held 0 -> two HOLD/WAIT_LOCK attempts (32-cycle waits), RETRY_CNT=1 then STATE=4, RETRY_CNT=2; check REQ-031/032 outputs in both builds.
REQ-036 Lock loss in RUN: drop PLL_LOCK -> LOCK_LOST single pulse, SYS_RESET=1 same cycle, STATE=0, then full re-sequence to RUN.
REQ-037 Priority: assert RESTART in the cycle the STABLE count completes -> STATE=0, SYS_RESET stays 1; assert RESET and RESTART together in FAULT -> REQ-027 values.
